// File: rtl/cla_pkg.sv
// cla_pkg: shared types, constants and 4-bit lookahead helpers for the pipelined CLA adder.
package cla_pkg;
  localparam int GROUP_W = 4;
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;
  function automatic logic [GROUP_W:0] lookahead4(input logic [GROUP_W-1:0] p, input logic [GROUP_W-1:0] g, input logic ci);
    logic [GROUP_W:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & ci);
    return c;
  endfunction
  function automatic pg_t group_pg(input logic [GROUP_W-1:0] p, input logic [GROUP_W-1:0] g);
    pg_t r;
    r.p = &p;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction
endpackage

// File: rtl/cla_segment.sv
// cla_segment: one combinational SEG_W-bit lookahead segment built from 4-bit groups.
module cla_segment import cla_pkg::*; #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             p,
  output logic             g
);
  localparam int NG = SEG_W / GROUP_W;
  logic [SEG_W-1:0] pb, gb;
  assign pb = a ^ b;
  assign gb = a & b;
  for (genvar j = 0; j < NG; j++) begin : g_grp
    logic [GROUP_W:0] c;
    logic ci, pa, ga;
    pg_t pg;
    if (j == 0) begin : g_lo
      assign ci = cin;
      assign pa = pg.p;
      assign ga = pg.g;
    end else begin : g_hi
      assign ci = g_grp[j-1].c[GROUP_W];
      assign pa = pg.p & g_grp[j-1].pa;
      assign ga = pg.g | (pg.p & g_grp[j-1].ga);
    end
    assign c = lookahead4(pb[j*GROUP_W +: GROUP_W], gb[j*GROUP_W +: GROUP_W], ci);
    assign pg = group_pg(pb[j*GROUP_W +: GROUP_W], gb[j*GROUP_W +: GROUP_W]);
    assign sum[j*GROUP_W +: GROUP_W] = pb[j*GROUP_W +: GROUP_W] ^ c[GROUP_W-1:0];
  end
  assign cout = g_grp[NG-1].c[GROUP_W];
  assign p = g_grp[NG-1].pa;
  assign g = g_grp[NG-1].ga;
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: segment-per-stage CLA adder/subtractor with valid/ready flow control.
// Define CLA_OVF_EN to compute and pipeline signed overflow; otherwise ovf is tied low.
module pipelined_cla_adder import cla_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operA,
  input  logic [WIDTH-1:0] operB,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultOUT,
  output logic             Cout,
  output logic             Pout,
  output logic             Gout,
  output logic             ovf
);
  localparam int SEGS = WIDTH / SEG_W;
  logic             advance;
  logic [WIDTH-1:0] beff;
  logic             cin0;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign beff     = sub ? ~operB : operB;
  assign cin0     = sub | Cin;
  // Each stage consumes the low segment of its remaining operands and appends its sum bits.
  for (genvar k = 0; k < SEGS; k++) begin : g_st
    localparam int IW = WIDTH - k * SEG_W;
    localparam int DW = (k + 1) * SEG_W;
    logic [IW-1:0]    a_i, b_i;
    logic [SEG_W-1:0] sum_k;
    logic [DW-1:0]    s_d, s_q;
    logic c_i, v_i, co, sp, sg, p_d, g_d;
    logic v_q, c_q, p_q, g_q;
    if (k == 0) begin : g_head
      assign a_i = operA;
      assign b_i = beff;
      assign c_i = cin0;
      assign v_i = in_valid;
      assign s_d = sum_k;
      assign p_d = sp;
      assign g_d = sg;
    end else begin : g_tail
      assign a_i = g_st[k-1].g_fwd.a_q;
      assign b_i = g_st[k-1].g_fwd.b_q;
      assign c_i = g_st[k-1].c_q;
      assign v_i = g_st[k-1].v_q;
      assign s_d = {sum_k, g_st[k-1].s_q};
      assign p_d = sp & g_st[k-1].p_q;
      assign g_d = sg | (sp & g_st[k-1].g_q);
    end
    cla_segment #(.SEG_W(SEG_W)) u_seg (
      .a    (a_i[SEG_W-1:0]),
      .b    (b_i[SEG_W-1:0]),
      .cin  (c_i),
      .sum  (sum_k),
      .cout (co),
      .p    (sp),
      .g    (sg)
    );
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        p_q <= 1'b0;
        g_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_i;
        if (v_i) begin
          c_q <= co;
          p_q <= p_d;
          g_q <= g_d;
          s_q <= s_d;
        end
      end
    end
    if (k < SEGS - 1) begin : g_fwd
      logic [IW-SEG_W-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_i) begin
          a_q <= a_i[IW-1:SEG_W];
          b_q <= b_i[IW-1:SEG_W];
        end
      end
    end
`ifdef CLA_OVF_EN
    else begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (advance && v_i) ovf_q <= (a_i[SEG_W-1] == b_i[SEG_W-1]) && (sum_k[SEG_W-1] != a_i[SEG_W-1]);
      end
    end
`endif
  end
  assign out_valid = g_st[SEGS-1].v_q;
  assign resultOUT = g_st[SEGS-1].s_q;
  assign Cout      = g_st[SEGS-1].c_q;
  assign Pout      = g_st[SEGS-1].p_q;
  assign Gout      = g_st[SEGS-1].g_q;
`ifdef CLA_OVF_EN
  assign ovf = g_st[SEGS-1].g_ovf.ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of SEG_W.
REQ-002 Parameter SEG_W, default 8, segment width in bits; one pipeline stage per segment; SHALL be a multiple of 4.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  operand beat offered.
REQ-006 Port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 Port operA  input  WIDTH  addend A.
REQ-008 Port operB  input  WIDTH  addend B.
REQ-009 Port Cin  input  1  carry-in; ignored when sub=1.
REQ-010 Port sub  input  1  0: A+B+Cin; 1: A+~B+1 (A-B).
REQ-011 Port out_valid  output  1  result beat present.
REQ-012 Port out_ready  input  1  downstream accepts result.
REQ-013 Port resultOUT  output  WIDTH  sum/difference.
REQ-014 Port Cout  output  1  carry out of MSB (borrow-not for sub).
REQ-015 Port Pout  output  1  group propagate over all WIDTH bits of the effective B.
REQ-016 Port Gout  output  1  group generate over all WIDTH bits of the effective B.
REQ-017 Port ovf  output  1  signed two's-complement overflow.

Function
REQ-018 Datapath: SEGS = WIDTH/SEG_W stages; stage k adds bits [k*SEG_W +: SEG_W] with 4-bit lookahead groups inside, carry from stage k-1 register.
REQ-019 Operand bits of not-yet-processed segments and completed result bits travel skewed in stage registers alongside the carry.
REQ-020 Latency: result of beat accepted at edge t visible on outputs after edge t+SEGS-1, absent stalls.
REQ-021 Throughput: one beat per cycle when out_ready=1 continuously.
REQ-022 advance = !out_valid || out_ready; all stages shift together only when advance=1; in_ready = advance.
REQ-023 While advance=0, every stage register, including resultOUT/Cout/Pout/Gout/ovf, SHALL hold.
REQ-024 Each stage carries a valid bit; bubbles propagate as valid=0; out_valid = last-stage valid bit.
REQ-025 Accepting in_valid with advance=0 is impossible; in_valid without in_ready SHALL not alter state.
REQ-026 Pout/Gout SHALL combine per-segment P/G in stage order using G = Gk | Pk&Gprev, P = Pk&Pprev.
REQ-027 ovf = (A[MSB] == Beff[MSB]) && (resultOUT[MSB] != A[MSB]); Beff = sub ? ~operB : operB.
REQ-028 Arithmetic modulo 2^WIDTH; Cout carries the (WIDTH+1)th bit.
REQ-029 sub, Cin sampled only with the accepted beat; changes on non-accepting cycles ignored.

Reset
REQ-030 rst_n=0 SHALL immediately clear all stage valid bits; out_valid=0; resultOUT, Cout, Pout, Gout, ovf = 0.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; no partial result emitted after release.
REQ-032 in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-033 Macro CLA_OVF_EN defined: ovf computed per REQ-027 and pipelined with its beat.
REQ-034 CLA_OVF_EN undefined: ovf tied 0, no overflow registers synthesised; port still present.

Structure
REQ-035 Package cla_pkg SHALL hold the pg_t struct (p, g), the 4-bit group-lookahead function, and the constant GROUP_W = 4.
REQ-036 One sub-module cla_segment SHALL implement one SEG_W-bit combinational lookahead segment (inputs a, b, cin; outputs sum, cout, p, g); the top instantiates SEGS copies plus registers.

Verification (WIDTH=32, SEG_W=8, latency 4)
REQ-037 A=0xFFFFFFFF, B=0x00000001, Cin=0, sub=0 -> resultOUT=0x00000000, Cout=1, Pout=0, Gout=1, ovf=0, out_valid 4 cycles after accept.
REQ-038 A=0x7FFFFFFF, B=0x00000001, sub=0 -> 0x80000000, Cout=0, ovf=1 (0 with CLA_OVF_EN undefined).
REQ-039 A=5, B=7, sub=1 -> 0xFFFFFFFE, Cout=0; A=7, B=5, sub=1 -> 0x00000002, Cout=1.
REQ-040 Back-to-back 10 random beats with out_ready=0 for cycles 5-8 -> in_ready low whenever out_valid=1 and out_ready=0, all 10 results in order, none lost or duplicated, outputs stable while stalled.
REQ-041 Three beats in flight, rst_n pulsed low for 1 cycle -> out_valid=0 immediately, no result from those beats ever appears, next beat completes with correct sum.
